// File: rtl/cgs_lane_align.sv
// rtl/cgs_lane_align.sv - per-lane code-group sync, comma-run tracking and octet re-alignment
module cgs_lane_align #(
    parameter int          BYTES   = 2,
    parameter logic [7:0]  COMMA   = 8'hBC,
    parameter int          K_MIN   = 4,
    parameter int          ERR_MAX = 3,
    localparam int         OW      = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [BYTES-1:0]       K,
    input  logic [BYTES-1:0][7:0]  DI,
    input  logic [BYTES-1:0]       ERR,
    output logic                   SYNC_N,
    output logic                   VALID,
    output logic [BYTES-1:0][7:0]  DO,
    output logic [BYTES-1:0]       KO,
    output logic [OW-1:0]          OFFS
);

    localparam int DIW = $clog2(2 * BYTES * 8);
    localparam int KIW = $clog2(2 * BYTES);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CHECK,
        ST_DATA
    } state_t;

    state_t                  state;
    logic [7:0]              run_cnt;
    logic [7:0]              run_nxt;
    logic [3:0]              err_cnt;
    logic [3:0]              err_nxt;
    logic                    err_hit;
    logic [BYTES-1:0]        is_comma;
    logic                    nc_found;
    logic [OW-1:0]           nc_idx;

    // Delayed input words; the selector reads two consecutive words so any offset can be served.
    logic [BYTES-1:0][7:0]   cur_d;
    logic [BYTES-1:0][7:0]   prev_d;
    logic [BYTES-1:0]        cur_k;
    logic [BYTES-1:0]        prev_k;
    logic                    data_d;
    logic [2*BYTES*8-1:0]    cat_d;
    logic [2*BYTES-1:0]      cat_k;
    logic [DIW-1:0]          bit_off;
    logic [KIW-1:0]          k_off;
    logic [BYTES*8-1:0]      sel_d;
    logic [BYTES-1:0]        sel_k;

    // Classify each octet as a valid comma (K set, no decode error, comma value).
    always_comb begin
        is_comma = '0;
        for (int i = 0; i < BYTES; i++) begin
            is_comma[i] = K[i] & ~ERR[i] & (DI[i] == COMMA);
        end
    end

    // Walk the word in stream order; the run carries over from the previous word and saturates at K_MIN.
    always_comb begin
        run_nxt = run_cnt;
        for (int i = 0; i < BYTES; i++) begin
            if (is_comma[i]) begin
                if (run_nxt != 8'(K_MIN)) begin
                    run_nxt = run_nxt + 8'd1;
                end
            end else begin
                run_nxt = '0;
            end
        end
    end

    // Consecutive errored-word count; err_hit marks the word that reaches ERR_MAX.
    always_comb begin
        if (|ERR) begin
            err_nxt = (err_cnt == 4'(ERR_MAX)) ? err_cnt : err_cnt + 4'd1;
        end else begin
            err_nxt = '0;
        end
        err_hit = (err_nxt == 4'(ERR_MAX));
    end

    // Lowest-index non-comma octet of the current word, scanned high to low so the lowest wins.
    always_comb begin
        nc_found = 1'b0;
        nc_idx   = '0;
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (!is_comma[i]) begin
                nc_found = 1'b1;
                nc_idx   = OW'(i);
            end
        end
    end

    // Octet selector: older word in the low half, newer word above it, window starts at OFFS.
    assign cat_d   = {cur_d, prev_d};
    assign cat_k   = {cur_k, prev_k};
    assign bit_off = DIW'({OFFS, 3'b000});
    assign k_off   = KIW'(OFFS);
    assign sel_d   = cat_d[bit_off +: BYTES*8];
    assign sel_k   = cat_k[k_off +: BYTES];

    // Synchronisation machine with registered SYNC_N and latched offset, plus the run/error counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_INIT;
            SYNC_N  <= 1'b0;
            OFFS    <= '0;
            run_cnt <= '0;
            err_cnt <= '0;
        end else begin
            run_cnt <= run_nxt;
            err_cnt <= err_nxt;
            case (state)
                ST_INIT: begin
                    if (run_nxt == 8'(K_MIN)) begin
                        state  <= ST_CHECK;
                        SYNC_N <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (err_hit) begin
                        state  <= ST_INIT;
                        SYNC_N <= 1'b0;
                    end else if (nc_found) begin
                        state <= ST_DATA;
                        OFFS  <= nc_idx;
                    end
                end
                ST_DATA: begin
                    if (err_hit) begin
                        state  <= ST_INIT;
                        SYNC_N <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    SYNC_N <= 1'b0;
                end
            endcase
        end
    end

    // Alignment pipeline; VALID needs two consecutive DATA cycles so the window holds only post-alignment octets.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_d  <= '0;
            prev_d <= '0;
            cur_k  <= '0;
            prev_k <= '0;
            DO     <= '0;
            KO     <= '0;
            data_d <= 1'b0;
            VALID  <= 1'b0;
        end else begin
            cur_d  <= DI;
            prev_d <= cur_d;
            cur_k  <= K;
            prev_k <= cur_k;
            DO     <= sel_d;
            KO     <= sel_k;
            data_d <= (state == ST_DATA);
            VALID  <= (state == ST_DATA) && data_d;
        end
    end

endmodule
